mux16_rr_arbiter: RTL and testbench

- Round-robin arbiter and select sequencer for the 16:1 data mux.
- Sixteen requesters share the single mux output. The arbiter grants exactly one requester at a time and drives the mux `s[3:0]` select with the winner's index.
- It also asserts a one-hot grant back to the winner, for as long as that winner holds the channel.
- It sits between the requester bank and the `mux16x1` instance. It is the only driver of the mux select.

---
 rtl/mux16_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_mux16_rr_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a 16:1 data mux.
// Grants one requester at a time, drives the mux select with the winner's
// index and returns a one-hot grant. Handoff between owners has no idle cycle.
// Optional hold timeout with preemption: define MUX_ARB_TIMEOUT_EN.
module mux16_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic [3:0]  s,
  output logic [15:0] gnt,
  output logic        valid,
  output logic        preempt
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e      state_q;
  logic [3:0]  ptr_q;
`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0]  cnt_q;
`endif

  // Search inputs: start point and candidate mask depend on whether the channel is owned.
  logic [3:0]  start;
  logic [15:0] cand;
  logic        found;
  logic [3:0]  win;
  logic [3:0]  idx;

  generate
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
      $error("MAX_HOLD must be in 1..255");
    end
  endgenerate

  // Circular first-set-bit search; when owned, scan from s+1 and skip the owner.
  always_comb begin
    start = ptr_q;
    cand  = req;
    found = 1'b0;
    win   = 4'd0;
    idx   = 4'd0;
    if (state_q == StGrant) begin
      start = s + 4'd1;
      cand  = req & ~(16'h0001 << s);
    end
    for (int i = 0; i < 16; i++) begin
      idx = start + 4'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 4'd0;
      s       <= 4'd0;
      gnt     <= 16'h0000;
      valid   <= 1'b0;
      preempt <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      preempt <= 1'b0;
      case (state_q)
        StIdle: begin
          if (found) begin
            s       <= win;
            gnt     <= 16'h0001 << win;
            valid   <= 1'b1;
            state_q <= StGrant;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
          end
        end
        StGrant: begin
          if (!req[s]) begin
            // Owner released: hand over directly or fall back to idle.
            ptr_q <= s + 4'd1;
            if (found) begin
              s     <= win;
              gnt   <= 16'h0001 << win;
`ifdef MUX_ARB_TIMEOUT_EN
              cnt_q <= 8'd0;
`endif
            end else begin
              valid   <= 1'b0;
              gnt     <= 16'h0000;
              state_q <= StIdle;
            end
          end else begin
`ifdef MUX_ARB_TIMEOUT_EN
            if (cnt_q == 8'(MAX_HOLD - 1)) begin
              if (found) begin
                // Hold budget spent with others waiting: revoke and pass on.
                ptr_q   <= s + 4'd1;
                s       <= win;
                gnt     <= 16'h0001 << win;
                preempt <= 1'b1;
              end
              cnt_q <= 8'd0;
            end else if (cnt_q != 8'hFF) begin
              cnt_q <= cnt_q + 8'd1;
            end
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed self-checking bench for mux16_rr_arbiter (MAX_HOLD = 4).
// Timeout-dependent expectations follow MUX_ARB_TIMEOUT_EN.
module tb_mux16_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [3:0]  s;
  logic [15:0] gnt;
  logic        valid;
  logic        preempt;

  int total;
  int bad;

  mux16_rr_arbiter #(
    .MAX_HOLD(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .s      (s),
    .gnt    (gnt),
    .valid  (valid),
    .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop all requests and let the arbiter return to idle.
  task automatic go_idle();
    req = 16'h0000;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 16'h0000;
    tick();
    tick();
    total++; if (s !== 4'd0) begin bad++; $display("FAIL reset_s got=%0d want=0", s); end
    total++; if (gnt !== 16'h0000) begin bad++; $display("FAIL reset_gnt got=%h want=0000", gnt); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (preempt !== 1'b0) begin bad++; $display("FAIL reset_preempt got=%b want=0", preempt); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    req = 16'h0010;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_pre_valid got=%b want=0", valid); end
    tick();
    total++; if (s !== 4'd4) begin bad++; $display("FAIL single_s got=%0d want=4", s); end
    total++; if (gnt !== 16'h0010) begin bad++; $display("FAIL single_gnt got=%h want=0010", gnt); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", valid); end
    req = 16'h0000;
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_rel_valid got=%b want=0", valid); end
    total++; if (gnt !== 16'h0000) begin bad++; $display("FAIL single_rel_gnt got=%h want=0000", gnt); end
    total++; if (s !== 4'd4) begin bad++; $display("FAIL single_rel_s got=%0d want=4", s); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_s [6];
    exp_s = '{4'd0, 4'd2, 4'd15, 4'd0, 4'd2, 4'd15};
    rst = 1'b1;
    req = 16'h0000;
    tick();
    rst = 1'b0;
    req = 16'h8005;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (s !== exp_s[k]) begin bad++; $display("FAIL rr_s[%0d] got=%0d want=%0d", k, s, exp_s[k]); end
      total++;
      if (valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%b want=1", k, valid); end
      // Owner releases for one edge while the others re-request.
      req = 16'h8005 & ~(16'h0001 << exp_s[k]);
    end
    go_idle();
  endtask

  task automatic test_handoff();
    req = 16'h0008;
    tick();
    total++; if (s !== 4'd3) begin bad++; $display("FAIL ho_own_s got=%0d want=3", s); end
    req = 16'h0088;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (s !== 4'd3) begin bad++; $display("FAIL ho_hold_s[%0d] got=%0d want=3", k, s); end
    end
    req = 16'h0080;
    tick();
    total++; if (s !== 4'd7) begin bad++; $display("FAIL ho_new_s got=%0d want=7", s); end
    total++; if (gnt !== 16'h0080) begin bad++; $display("FAIL ho_new_gnt got=%h want=0080", gnt); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL ho_valid got=%b want=1", valid); end
    go_idle();
  endtask

  task automatic test_preempt();
    logic [3:0] exp_s;
    logic       exp_p;
    req = 16'h0003;
    for (int k = 0; k < 12; k++) begin
      tick();
`ifdef MUX_ARB_TIMEOUT_EN
      exp_s = ((k / 4) % 2 == 1) ? 4'd1 : 4'd0;
      exp_p = (k == 4 || k == 8);
`else
      exp_s = 4'd0;
      exp_p = 1'b0;
`endif
      total++;
      if (s !== exp_s) begin bad++; $display("FAIL pre_s[%0d] got=%0d want=%0d", k, s, exp_s); end
      total++;
      if (preempt !== exp_p) begin bad++; $display("FAIL pre_pulse[%0d] got=%b want=%b", k, preempt, exp_p); end
    end
    go_idle();
  endtask

  task automatic test_lone_owner();
    req = 16'h0020;
    for (int k = 0; k < 20; k++) begin
      tick();
      total++;
      if (s !== 4'd5 || valid !== 1'b1 || preempt !== 1'b0) begin
        bad++;
        $display("FAIL lone[%0d] got s=%0d v=%b p=%b want s=5 v=1 p=0", k, s, valid, preempt);
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    req = 16'h0200;
    tick();
    total++; if (s !== 4'd9) begin bad++; $display("FAIL rm_own_s got=%0d want=9", s); end
    rst = 1'b1;
    req = 16'h0201;
    tick();
    total++;
    if (s !== 4'd0 || gnt !== 16'h0000 || valid !== 1'b0 || preempt !== 1'b0) begin
      bad++;
      $display("FAIL rm_reset got s=%0d g=%h v=%b p=%b want all 0", s, gnt, valid, preempt);
    end
    rst = 1'b0;
    tick();
    total++; if (s !== 4'd0) begin bad++; $display("FAIL rm_after_s got=%0d want=0", s); end
    total++; if (gnt !== 16'h0001) begin bad++; $display("FAIL rm_after_gnt got=%h want=0001", gnt); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL rm_after_valid got=%b want=1", valid); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 16'h0000;
    test_reset();
    test_single();
    test_round_robin();
    test_handoff();
    test_preempt();
    test_lone_owner();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
